// File: rtl/r22sdf_pkg.sv
// Shared types and sizing helpers for the radix-2^2 SDF frame controller.
package r22sdf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAD   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) res = i + 32'd1;
        end
        return res;
    endfunction

    localparam int unsigned FFT_LEN_DEF  = 16;
    localparam int unsigned IN_CNT_W_DEF = clog2(FFT_LEN_DEF);

endpackage

// File: rtl/r22sdf_tag_pipe.sv
// Enable-gated tag delay line mirroring the FFT latency, plus a count of
// tagged (real) samples currently inside the pipeline.
module r22sdf_tag_pipe
    import r22sdf_pkg::*;
#(
    parameter  int unsigned PIPE_LAT = 24,
    localparam int unsigned LIVE_W   = clog2(PIPE_LAT + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              tag_i,
    output logic              tag_o,
    output logic [LIVE_W-1:0] live_o
);

    logic [PIPE_LAT-1:0] sr_q, sr_d;
    logic [LIVE_W-1:0]   live_q, live_d;

    always_comb begin
        sr_d   = sr_q;
        live_d = live_q;
        if (en_i) begin
            sr_d[0] = tag_i;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                sr_d[i] = sr_q[i - 1];
            end
            if (tag_i && !sr_q[PIPE_LAT-1]) begin
                live_d = live_q + LIVE_W'(1);
            end else if (!tag_i && sr_q[PIPE_LAT-1]) begin
                live_d = live_q - LIVE_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q   <= '0;
            live_q <= '0;
        end else begin
            sr_q   <= sr_d;
            live_q <= live_d;
        end
    end

    assign tag_o  = sr_q[PIPE_LAT-1];
    assign live_o = live_q;

endmodule

// File: rtl/r22sdf_frame_ctrl.sv
// Frame sequencer for the R2^2 SDF FFT: input handshake, zero padding of a
// partial last frame, pipeline drain and output valid/sop/eop tagging.
module r22sdf_frame_ctrl
    import r22sdf_pkg::*;
#(
    parameter int unsigned FFT_LEN     = FFT_LEN_DEF,
    parameter int unsigned PIPE_LAT    = 24,
    parameter int unsigned FRAME_CNT_W = 8
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   s_valid,
    input  logic                   s_sop,
    output logic                   s_ready,
    input  logic                   flush_req,
    input  logic                   fft_rdy,
    output logic                   fft_en,
    output logic                   fft_zero_in,
    output logic                   m_valid,
    output logic                   m_sop,
    output logic                   m_eop,
    output logic [FRAME_CNT_W-1:0] m_frame_cnt,
    output logic                   busy,
    output logic                   done,
    output logic                   err_sop
);

    localparam int unsigned CNT_W  = clog2(FFT_LEN);
    localparam int unsigned LIVE_W = clog2(PIPE_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FFT_LEN - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic               err_sop_q, err_sop_d;
    logic               flush_pend_q, flush_pend_d;
    logic               m_valid_q, m_sop_q, m_eop_q;
    logic               done_pend_q, done_q;
    logic               accept, tag_in, tag_out, drain_done, out_fire;
    logic [LIVE_W-1:0]  live;

    r22sdf_tag_pipe #(.PIPE_LAT(PIPE_LAT)) u_tag_pipe (
        .clk_i  (sys_clk),
        .rst_i  (sys_rst),
        .en_i   (fft_en),
        .tag_i  (tag_in),
        .tag_o  (tag_out),
        .live_o (live)
    );

    // Handshake, pipeline enable and next-state; fft_rdy low freezes everything.
    always_comb begin
        s_ready      = 1'b0;
        fft_en       = 1'b0;
        fft_zero_in  = 1'b0;
        tag_in       = 1'b0;
        accept       = 1'b0;
        drain_done   = 1'b0;
        state_d      = state_q;
        in_cnt_d     = in_cnt_q;
        err_sop_d    = err_sop_q;
        flush_pend_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                s_ready = fft_rdy;
                accept  = s_valid & fft_rdy;
                fft_en  = accept;
                tag_in  = accept;
                if (accept) begin
                    if (s_sop && in_cnt_q != '0) begin
                        err_sop_d = 1'b1;
                        in_cnt_d  = CNT_W'(1);
                    end else begin
                        in_cnt_d  = in_cnt_q + CNT_W'(1);
                    end
                    if (state_q == ST_IDLE) state_d = ST_RUN;
                end
                // A flush seen during a stall is held until the pipeline can move.
                if (state_q == ST_RUN && (flush_req || flush_pend_q)) begin
                    if (fft_rdy) begin
                        state_d = (in_cnt_d == '0) ? ST_DRAIN : ST_PAD;
                    end else begin
                        flush_pend_d = 1'b1;
                    end
                end
            end
            ST_PAD: begin
                fft_zero_in = 1'b1;
                fft_en      = fft_rdy;
                tag_in      = 1'b1;
                if (fft_rdy) begin
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                    if (in_cnt_d == '0) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                fft_zero_in = 1'b1;
                fft_en      = fft_rdy;
                if (fft_rdy && (live == '0 || (live == LIVE_W'(1) && tag_out))) begin
                    state_d    = ST_IDLE;
                    drain_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_fire = fft_en & tag_out;

    // done trails the final m_valid by one cycle so the frame is fully out.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            err_sop_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            m_valid_q    <= 1'b0;
            m_sop_q      <= 1'b0;
            m_eop_q      <= 1'b0;
            done_pend_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            err_sop_q    <= err_sop_d;
            flush_pend_q <= flush_pend_d;
            m_valid_q    <= out_fire;
            m_sop_q      <= out_fire & (out_cnt_q == '0);
            m_eop_q      <= out_fire & (out_cnt_q == CNT_LAST);
            if (out_fire) out_cnt_q <= out_cnt_q + CNT_W'(1);
            if (m_eop_q) frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
            done_pend_q  <= drain_done;
            done_q       <= done_pend_q;
        end
    end

    assign m_valid     = m_valid_q;
    assign m_sop       = m_sop_q;
    assign m_eop       = m_eop_q;
    assign m_frame_cnt = frame_cnt_q;
    assign done        = done_q;
    assign err_sop     = err_sop_q;
    assign busy        = (state_q != ST_IDLE) | (live != '0);

endmodule

// File: tb/tb_r22sdf_frame_ctrl.sv
// Scoreboard bench for r22sdf_frame_ctrl: stimulus pushes expected output tags,
// a negedge monitor pops and compares them whenever m_valid is high.
module tb_r22sdf_frame_ctrl;

    localparam int unsigned FFT_LEN     = 16;
    localparam int unsigned PIPE_LAT    = 24;
    localparam int unsigned FRAME_CNT_W = 8;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] fcnt;
    } exp_t;

    logic clk;
    logic sys_rst, s_valid, s_sop, flush_req, fft_rdy;
    logic s_ready, fft_en, fft_zero_in, m_valid, m_sop, m_eop, busy, done, err_sop;
    logic [FRAME_CNT_W-1:0] m_frame_cnt;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   t       = 0;
    int   n_out   = 0;
    int   en_cnt  = 0;
    int   zen_cnt = 0;
    int   out_idx = 0;
    exp_t exp_q[$];
    int   mv_times[$];
    int   done_times[$];

    r22sdf_frame_ctrl #(
        .FFT_LEN     (FFT_LEN),
        .PIPE_LAT    (PIPE_LAT),
        .FRAME_CNT_W (FRAME_CNT_W)
    ) dut (
        .sys_clk     (clk),
        .sys_rst     (sys_rst),
        .s_valid     (s_valid),
        .s_sop       (s_sop),
        .s_ready     (s_ready),
        .flush_req   (flush_req),
        .fft_rdy     (fft_rdy),
        .fft_en      (fft_en),
        .fft_zero_in (fft_zero_in),
        .m_valid     (m_valid),
        .m_sop       (m_sop),
        .m_eop       (m_eop),
        .m_frame_cnt (m_frame_cnt),
        .busy        (busy),
        .done        (done),
        .err_sop     (err_sop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            t++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, t, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic sp, input logic fl, input logic rdy);
        s_valid   = v;
        s_sop     = sp;
        flush_req = fl;
        fft_rdy   = rdy;
    endtask

    // Output n of the stream (since reset) is position n%16 of frame n/16.
    function automatic void push_exp();
        exp_t e;
        e.sop  = (n_out % 16) == 0;
        e.eop  = (n_out % 16) == 15;
        e.fcnt = 8'((n_out / 16) % 256);
        exp_q.push_back(e);
        n_out++;
    endfunction

    task automatic wait_done(input int lim, input string nm, input int d0);
        int k;
        k = 0;
        while (done_times.size() == d0 && k < lim) begin
            step();
            k++;
        end
        step();
        chk({nm, "_done_pulses"}, done_times.size() - d0, 1);
    endtask

    // Monitor: scoreboard pop on every m_valid, plus event logging.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (fft_en) en_cnt++;
            if (fft_en && fft_zero_in) zen_cnt++;
            if (done) done_times.push_back(t);
            if (m_valid) begin
                mv_times.push_back(t);
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_unexpected at cycle %0d: got m_valid=1, want no output", t);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_sop, m_eop, m_frame_cnt} !== {e.sop, e.eop, e.fcnt}) begin
                        n_fail++;
                        $display("FAIL out_tag #%0d at cycle %0d: got sop=%b eop=%b fcnt=%0d, want sop=%b eop=%b fcnt=%0d",
                                 out_idx, t, m_sop, m_eop, m_frame_cnt, e.sop, e.eop, e.fcnt);
                    end
                end
                out_idx++;
            end
        end
    end

    // Two full frames back to back with flush on the last sample.
    task automatic scen_full(input string nm);
        int b, m0, z0, d0;
        b  = 0;
        m0 = mv_times.size();
        z0 = zen_cnt;
        d0 = done_times.size();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, (i % 16) == 0, i == 31, 1'b1);
            if (i == 0) b = t;
            push_exp();
            #1;
            if (i == 0 || i == 31) begin
                chk({nm, "_s_ready"}, int'(s_ready), 1);
                chk({nm, "_fft_en"}, int'(fft_en), 1);
            end
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        wait_done(120, nm, d0);
        chk({nm, "_first_mv"}, (mv_times.size() > m0) ? mv_times[m0] - b : -1, 25);
        chk({nm, "_last_mv"}, (mv_times.size() > m0) ? mv_times[$] - b : -1, 56);
        chk({nm, "_mv_count"}, mv_times.size() - m0, 32);
        chk({nm, "_done_cycle"}, (done_times.size() > d0) ? done_times[$] - b : -1, 57);
        chk({nm, "_drain_len"}, zen_cnt - z0, 24);
        chk({nm, "_frame_cnt"}, int'(m_frame_cnt), 2);
        chk({nm, "_busy_after"}, int'(busy), 0);
        chk({nm, "_err_sop"}, int'(err_sop), 0);
        chk({nm, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin : stim
        int m0, z0, d0, e0;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        sys_rst = 1'b1;
        step();
        step();
        sys_rst = 1'b0;
        #1;
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err_sop", int'(err_sop), 0);
        chk("rst_frame_cnt", int'(m_frame_cnt), 0);
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_fft_en", int'(fft_en), 0);
        step();

        // Flush in IDLE with an empty pipeline is ignored.
        e0 = en_cnt;
        d0 = done_times.size();
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        chk("idle_flush_en", int'(fft_en), 0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (30) step();
        chk("idle_flush_no_en", en_cnt - e0, 0);
        chk("idle_flush_no_done", done_times.size() - d0, 0);
        chk("idle_flush_busy", int'(busy), 0);

        scen_full("s1");

        // Partial frame: 5 samples, then 11 zero pads tagged as real outputs.
        m0 = mv_times.size();
        z0 = zen_cnt;
        d0 = done_times.size();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, i == 0, i == 4, 1'b1);
            push_exp();
            step();
        end
        for (int i = 0; i < 11; i++) push_exp();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("s2_pad_zero_in", int'(fft_zero_in), 1);
        chk("s2_pad_s_ready", int'(s_ready), 0);
        chk("s2_pad_fft_en", int'(fft_en), 1);
        wait_done(120, "s2", d0);
        chk("s2_mv_count", mv_times.size() - m0, 16);
        chk("s2_zero_cycles", zen_cnt - z0, 35);
        chk("s2_queue_empty", exp_q.size(), 0);
        chk("s2_busy_after", int'(busy), 0);

        // fft_rdy stall of 10 cycles while outputs are flowing.
        m0 = mv_times.size();
        z0 = zen_cnt;
        d0 = done_times.size();
        for (int i = 0; i < 32; i++) begin
            if (i == 28) begin
                for (int j = 0; j < 10; j++) begin
                    drive(1'b1, 1'b0, 1'b0, 1'b0);
                    #1;
                    chk("s3_stall_s_ready", int'(s_ready), 0);
                    chk("s3_stall_fft_en", int'(fft_en), 0);
                    if (j > 0) chk("s3_stall_m_valid", int'(m_valid), 0);
                    step();
                end
            end
            drive(1'b1, (i % 16) == 0, i == 31, 1'b1);
            push_exp();
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        wait_done(120, "s3", d0);
        chk("s3_mv_count", mv_times.size() - m0, 32);
        chk("s3_drain_len", zen_cnt - z0, 24);
        chk("s3_queue_empty", exp_q.size(), 0);

        // Misplaced sop on the 8th sample resyncs the frame: boundary 15 samples later.
        m0 = mv_times.size();
        z0 = zen_cnt;
        d0 = done_times.size();
        for (int i = 0; i < 23; i++) begin
            drive(1'b1, i == 0 || i == 7, i == 22, 1'b1);
            push_exp();
            if (i == 7) begin
                #1;
                chk("s4_err_before", int'(err_sop), 0);
            end
            step();
            if (i == 7) chk("s4_err_set", int'(err_sop), 1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        wait_done(120, "s4", d0);
        chk("s4_mv_count", mv_times.size() - m0, 23);
        chk("s4_no_pad", zen_cnt - z0, 24);
        chk("s4_err_sticky", int'(err_sop), 1);
        chk("s4_queue_empty", exp_q.size(), 0);

        // Reset in the middle of DRAIN discards in-flight tags.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i == 0, i == 15, 1'b1);
            push_exp();
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (12) step();
        chk("s5_busy_pre", int'(busy), 1);
        d0 = done_times.size();
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        exp_q.delete();
        n_out = 0;
        out_idx = 0;
        m0 = mv_times.size();
        #1;
        chk("s5_rst_busy", int'(busy), 0);
        chk("s5_rst_m_valid", int'(m_valid), 0);
        chk("s5_rst_frame_cnt", int'(m_frame_cnt), 0);
        chk("s5_rst_err_sop", int'(err_sop), 0);
        chk("s5_rst_fft_en", int'(fft_en), 0);
        repeat (40) step();
        chk("s5_no_done", done_times.size() - d0, 0);
        chk("s5_no_mv", mv_times.size() - m0, 0);
        scen_full("s5_fresh");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
